siso_xfer_sched: RTL and testbench
==================================

Name: siso_xfer_sched

Overview:
- Round-robin scheduler that shares one external DEPTH-stage SISO shift register (ports si/so) between NREQ requesters.
- Accepts a parallel word from the winning requester and serialises it MSB-first into the shift register's si.
- Flushes the pipe and deserialises the word arriving on so back into a parallel response tagged with the requester id.
- Sits between requester logic and the siso datapath.

Parameters:
- WIDTH, 8, bits per transfer word
- DEPTH, 4, stage count (latency in clocks) of the attached SISO register
- NREQ, 2, number of requesters (>=2)

Ports:
- clk  in  1  rising-edge clock, shared with the SISO register
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*WIDTH  packed words; requester k owns bits [k*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept pulse; word k is taken when valid&ready
- sr_si  out  1  serial data to SISO si
- sr_so  in  1  serial data from SISO so
- rsp_valid  out  1  response word valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  WIDTH  deserialised word, MSB first received
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the response
- busy  out  1  high in every state except IDLE
- rsp_err  out  1  loopback mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, rr pointer=NREQ-1 (so requester 0 wins first), cnt=0.
  - sr_si=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, rsp_err=0.
- All outputs are registered. Reset mid-transfer aborts the transfer and drops any pending response; the SISO contents are don't-care.
- FSM states: IDLE, SHIFT, FLUSH, RESP.
- IDLE:
  - If any req_valid is set, grant the first requester after the rr pointer (wrapping).
  - Load req_data of the granted requester into tx_sh and pulse req_ready[g] for exactly one cycle (the load cycle).
  - Record rsp_id=g and set the rr pointer to g. Next state is SHIFT with cnt=0.
- SHIFT (WIDTH cycles):
  - sr_si = tx_sh[WIDTH-1]; tx_sh shifts left each clock.
  - cnt increments each clock. Exit to FLUSH after cnt=WIDTH-1.
- FLUSH (DEPTH cycles): sr_si=0, cnt continues. Exit to RESP after cnt=WIDTH+DEPTH-1.
- Capture:
  - Bit i is driven during transfer cycle i and appears on sr_so during cycle i+DEPTH.
  - At each rising edge ending a cycle with cnt in [DEPTH, DEPTH+WIDTH-1], sample rx_sh = {rx_sh[WIDTH-2:0], sr_so}.
  - Exactly WIDTH samples are taken; the sample count is independent of the SHIFT/FLUSH boundary.
- RESP:
  - rsp_valid=1 and rsp_data=rx_sh, both held stable while rsp_ready=0.
  - On a cycle with rsp_valid&rsp_ready, go to IDLE and clear rsp_valid the following cycle.
  - New grants are not issued until IDLE, so at most one transfer is in flight.
- Total latency from accept to rsp_valid is WIDTH+DEPTH+1 clocks.
- Requests whose req_valid drops before grant are simply not granted; no request is queued internally.
- cnt width is $clog2(WIDTH+DEPTH+1); it never wraps within a transfer.

Optional Feature:
- Macro: SISO_XFER_CHECK_EN.
- When defined:
  - The accepted word is kept in a shadow register.
  - rsp_err is set together with rsp_valid when rx_sh != shadow, and holds with rsp_valid.
- When undefined: no shadow register, and rsp_err is tied 0.

Decomposition:
- Package siso_xfer_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, RESP} xfer_state_t
  - default WIDTH/DEPTH/NREQ localparams
  - function clog2_min1, which returns a port width of at least 1
- One sub-module: siso_rr_arb (NREQ-way round-robin grant from valid vector + pointer, combinational, one-hot output).
- The FSM, counter, and shift registers stay in siso_xfer_sched.

Test Plan:
- Single transfer: req_valid=2'b01, req_data[7:0]=8'hA5 with the DUT wired to a 4-stage siso model -> req_ready=01 for 1 cycle; rsp_valid rises 13 clocks after accept with rsp_data=8'hA5, rsp_id=0; sr_si shows 1,0,1,0,0,1,0,1.
- Round-robin: both requesters hold valid continuously (words 8'h3C and 8'hC3) -> grants alternate 0,1,0,1; responses 3C/id0, C3/id1, repeated.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stay stable; no req_ready pulse occurs; the transfer completes when rsp_ready=1.
- Reset mid-SHIFT: assert rst_n=0 at cnt=3 -> all outputs are at reset values immediately (asynchronously); after release, requester 0 wins first and the next transfer (8'hFF) returns 8'hFF.
- Boundary words: 8'h00, then 8'hFF, then 8'h80 -> each returned exactly; verifies the first and last capture cycles and the FLUSH zero-fill.
- SISO_XFER_CHECK_EN defined, so forced inverted on one bit during capture -> rsp_err=1 with rsp_valid; clean transfer -> rsp_err=0.

Source files
------------

// File: rtl/siso_xfer_pkg.sv
// Shared types and defaults for the SISO transfer scheduler.
package siso_xfer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, RESP} xfer_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NREQ  = 2;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/siso_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first valid requester after ptr.
module siso_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // i runs to NREQ so the pointer's own requester is considered last
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!any && valid[k]) begin
        any      = 1'b1;
        idx      = IW'(k);
        grant[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/siso_xfer_sched.sv
// Round-robin scheduler sharing one external DEPTH-stage SISO register among NREQ requesters.
// Optional loopback check: define SISO_XFER_CHECK_EN to compare the returned word with the sent one.
module siso_xfer_sched
  import siso_xfer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic                          sr_si,
  input  logic                          sr_so,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [clog2_min1(NREQ)-1:0]   rsp_id,
  output logic                          busy,
  output logic                          rsp_err
);
  localparam int IW = clog2_min1(NREQ);
  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);
  localparam logic [CW-1:0] XFER_LAST  = CW'(WIDTH + DEPTH - 1);

  xfer_state_t       state, nxt;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     ptr, gidx;
  logic [NREQ-1:0]   gnt;
  logic              gany;
  logic [WIDTH-1:0]  tx_sh, rx_sh, rx_next, word;
  logic              capture;

  siso_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gidx),
    .any   (gany)
  );

  assign word    = req_data[gidx*WIDTH +: WIDTH];
  assign rx_next = {rx_sh[WIDTH-2:0], sr_so};
  // Window is counter-based so it spans the SHIFT/FLUSH boundary unchanged
  assign capture = (state == SHIFT || state == FLUSH) && (cnt >= CAP_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (gany)              nxt = SHIFT;
      SHIFT:   if (cnt == SHIFT_LAST) nxt = FLUSH;
      FLUSH:   if (cnt == XFER_LAST)  nxt = RESP;
      RESP:    if (rsp_ready)         nxt = IDLE;
      default:                        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= IW'(NREQ - 1);
      cnt       <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      sr_si     <= 1'b0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      busy      <= (nxt != IDLE);
      if (capture) rx_sh <= rx_next;
      case (state)
        IDLE: if (gany) begin
          // MSB goes straight to sr_si so bit i is on the wire while cnt == i
          req_ready <= gnt;
          sr_si     <= word[WIDTH-1];
          tx_sh     <= {word[WIDTH-2:0], 1'b0};
          rsp_id    <= gidx;
          ptr       <= gidx;
          cnt       <= '0;
        end
        SHIFT: begin
          sr_si <= tx_sh[WIDTH-1];
          tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
        end
        FLUSH: begin
          sr_si <= 1'b0;
          cnt   <= cnt + 1'b1;
          if (cnt == XFER_LAST) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rx_next;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SISO_XFER_CHECK_EN
  logic [WIDTH-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && gany) shadow <= word;
      if (state == FLUSH && cnt == XFER_LAST) rsp_err <= (rx_next != shadow);
      else if (state == RESP && rsp_ready)    rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_siso_xfer_sched.sv
// Self-checking bench: vector table, hand-written corner sequences, random traffic vs. a loopback model.
module tb_siso_xfer_sched;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 2;
`ifdef SISO_XFER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           sr_si, sr_so;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic [0:0]     rsp_id;
  logic           busy, rsp_err;
  logic           flip = 1'b0;
  logic [D-1:0]   pipe = '0;
  int             ncmp = 0, nerr = 0;

  typedef struct {
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    int             id;
    logic [W-1:0]   w;
    int             bp;
  } vec_t;

  siso_xfer_sched #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sr_si(sr_si), .sr_so(sr_so), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // External D-stage SISO register; flip corrupts the returned stream
  always @(posedge clk) pipe <= {pipe[D-2:0], sr_si};
  assign sr_so = pipe[D-1] ^ flip;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transfer: grant, serial stream, flush, latency, response, optional backpressure.
  task automatic xfer(input logic [N-1:0] v, input logic [N*W-1:0] d, input int eid,
                      input logic [W-1:0] ew, input logic eerr, input int fl, input int bp);
    int t;
    logic [W-1:0] ser, sent;
    logic flz;
    sent = d[eid*W +: W];
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = (bp == 0);
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready == '0 && t < 40);
    check("grant", req_ready, oh(eid));
    if (req_ready == '0) begin req_valid = '0; return; end
    req_valid = '0;
    ser = '0;
    flz = 1'b0;
    for (int r = 0; r < W + D; r++) begin
      if (r > 0) @(negedge clk);
      if (r < W) ser[W-1-r] = sr_si;
      else       flz = flz | sr_si;
      flip = (fl >= 0 && r == D + fl);
    end
    check("serial_out", ser, sent);
    check("flush_zero", flz, 1'b0);
    t = W + D - 1;
    do begin @(negedge clk); flip = 1'b0; t++; end while (!rsp_valid && t < W + D + 20);
    // grant decision is made one cycle before the registered ready pulse
    check("latency", t + 1, W + D + 1);
    check("rsp_data", rsp_data, ew);
    check("rsp_id", rsp_id, eid);
    check("rsp_err", rsp_err, eerr);
    for (int b = 0; b < bp; b++) begin
      req_valid = '1;
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_data, rsp_id, rsp_err, req_ready},
            {1'b1, ew, eid[0], eerr, 2'b00});
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_clear", {rsp_valid, rsp_err, busy}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int t, g, mptr, t_rdy, ei;
    bit inflight, seen;
    logic [N-1:0] pend, prev_v;
    logic [W-1:0] pdat [N];
    logic [W-1:0] ed;
    int q_id[$];
    logic [W-1:0] q_dat[$];

    tbl[0] = '{2'b01, {8'h00, 8'hA5}, 0, 8'hA5, 0};
    tbl[1] = '{2'b10, {8'h00, 8'h77}, 1, 8'h00, 0};
    tbl[2] = '{2'b11, {8'h11, 8'hFF}, 0, 8'hFF, 0};
    tbl[3] = '{2'b11, {8'h80, 8'h22}, 1, 8'h80, 0};
    tbl[4] = '{2'b01, {8'h5A, 8'h96}, 0, 8'h96, 10};
    tbl[5] = '{2'b11, {8'hC3, 8'h3C}, 1, 8'hC3, 0};

    repeat (2) @(negedge clk);
    check("reset_state", {req_ready, sr_si, rsp_valid, rsp_data, rsp_id, busy, rsp_err}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      xfer(tbl[i].v, tbl[i].d, tbl[i].id, tbl[i].w, 1'b0, -1, tbl[i].bp);

    // Asynchronous reset in the middle of SHIFT (cnt == 3)
    @(negedge clk);
    req_valid = 2'b01;
    req_data  = {8'hEE, 8'h12};
    rsp_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready == '0 && t < 40);
    check("rst_grant", req_ready, 2'b01);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("busy_mid", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {req_ready, sr_si, rsp_valid, rsp_data, rsp_id, busy, rsp_err}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(2'b11, {8'hEE, 8'hFF}, 0, 8'hFF, 1'b0, -1, 0);

    // Both requesters hold valid: grants alternate starting at 0
    do_reset();
    req_valid = '1;
    req_data  = {8'hC3, 8'h3C};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (req_ready == '0 && t < 40);
      check("rr_grant", req_ready, oh(i % 2));
      t = 0;
      do begin @(negedge clk); t++; end while (!rsp_valid && t < 40);
      check("rr_data", rsp_data, (i % 2) ? 8'hC3 : 8'h3C);
      check("rr_id", rsp_id, i % 2);
    end
    req_valid = '0;
    @(negedge clk);

    // Corrupt returned bit 2 (word bit 5), then a clean transfer
    xfer(2'b01, {8'h00, 8'hB4}, 0, 8'h94, CHK, 2, 0);
    xfer(2'b10, {8'h6B, 8'h00}, 1, 8'h6B, 1'b0, -1, 0);

    // Random traffic against a loopback model: response == word granted, in grant order
    do_reset();
    mptr = N - 1;
    inflight = 1'b0;
    seen = 1'b0;
    t_rdy = 0;
    pend = '0;
    prev_v = '0;
    for (int k = 0; k < N; k++) pdat[k] = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = -1;
        for (int i = 1; i <= N; i++)
          if (g < 0 && prev_v[(mptr + i) % N]) g = (mptr + i) % N;
        check("rnd_grant", req_ready, (g < 0) ? '0 : oh(g));
        check("rnd_overlap", inflight, 1'b0);
        if (g >= 0) begin
          q_id.push_back(g);
          q_dat.push_back(pdat[g]);
          mptr = g;
          pend[g] = 1'b0;
          inflight = 1'b1;
          t_rdy = c;
          seen = 1'b0;
        end
      end
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        check("rnd_latency", c - t_rdy + 1, W + D + 1);
      end
      for (int k = 0; k < N; k++)
        if (!pend[k] && c < 2900 && $urandom_range(0, 3) == 0) begin
          pend[k] = 1'b1;
          pdat[k] = W'($urandom);
        end
      req_valid = pend;
      for (int k = 0; k < N; k++) req_data[k*W +: W] = pdat[k];
      rsp_ready = (c >= 2900) || ($urandom_range(0, 2) != 0);
      prev_v = pend;
      if (rsp_valid && rsp_ready) begin
        if (q_id.size() == 0) check("rnd_spurious_rsp", rsp_valid, 1'b0);
        else begin
          ed = q_dat.pop_front();
          ei = q_id.pop_front();
          check("rnd_data", rsp_data, ed);
          check("rnd_id", rsp_id, ei);
          check("rnd_err", rsp_err, 1'b0);
          inflight = 1'b0;
        end
      end
    end
    check("rnd_drain", {inflight, pend, busy}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
